// File: rtl/safebox_lock_ctrl_if.sv
// Keypad strobes toward the lock controller and its status outputs toward the display.
interface safebox_lock_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_enter;
    logic       key_clear;
    logic       lock_cmd;
    logic       set_cmd;
    logic       state;
    logic       lockout;
    logic [2:0] fail_cnt;
    logic [3:0] digit_cnt;
    logic       err_pulse;
    logic       ok_pulse;

    modport master (
        output key_valid, key_code, key_enter, key_clear, lock_cmd, set_cmd,
        input  state, lockout, fail_cnt, digit_cnt, err_pulse, ok_pulse
    );

    modport slave (
        input  key_valid, key_code, key_enter, key_clear, lock_cmd, set_cmd,
        output state, lockout, fail_cnt, digit_cnt, err_pulse, ok_pulse
    );
endinterface

// File: rtl/safebox_lock_ctrl.sv
// Safe box code entry/compare/lockout sequencer; SAFEBOX_AUTO_RELOCK_EN adds idle auto-relock.
// Latency: all outputs registered; key_enter at N gives ok/err_pulse at N+1, state/lockout at N+2.
// Backpressure: none; single-cycle strobes, anything arriving in a busy state is dropped.
module safebox_lock_ctrl #(
    parameter int                    DIGITS             = 4,
    parameter logic [DIGITS*4-1:0]   DEFAULT_CODE       = 16'h1234,
    parameter int                    MAX_FAIL           = 3,
    parameter int                    LOCKOUT_CYCLES     = 250000000,
    parameter int                    AUTO_RELOCK_CYCLES = 500000000
) (
    input logic               clk,
    input logic               rst,
    safebox_lock_ctrl_if.slave bus
);
    localparam int CW      = DIGITS * 4;
    localparam int MAX_CYC = (LOCKOUT_CYCLES > AUTO_RELOCK_CYCLES) ? LOCKOUT_CYCLES : AUTO_RELOCK_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {
        S_LOCKED   = 3'd0,
        S_CHECK    = 3'd1,
        S_OPEN     = 3'd2,
        S_OPEN_SET = 3'd3,
        S_LOCKOUT  = 3'd4
    } st_t;

    st_t           st_q, st_d;
    logic [CW-1:0] code_q, code_d;
    logic [CW-1:0] ebuf_q, ebuf_d;
    logic [3:0]    dcnt_q, dcnt_d;
    logic [2:0]    fcnt_q, fcnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          match_q, match_d;
    logic          err_q, err_d;
    logic          ok_q, ok_d;
    logic          state_q, lockout_q;
    logic          full;
    logic [CW-1:0] shifted;
    logic [2:0]    fail_next;
`ifdef SAFEBOX_AUTO_RELOCK_EN
    logic [TW-1:0] idle_q, idle_d;
`endif

    always_comb begin
        st_d      = st_q;
        code_d    = code_q;
        ebuf_d    = ebuf_q;
        dcnt_d    = dcnt_q;
        fcnt_d    = fcnt_q;
        tmr_d     = tmr_q;
        match_d   = match_q;
        err_d     = 1'b0;
        ok_d      = 1'b0;
        full      = (dcnt_q == 4'(DIGITS));
        shifted   = (ebuf_q << 4) | CW'(bus.key_code);
        fail_next = (fcnt_q >= 3'(MAX_FAIL)) ? 3'(MAX_FAIL) : fcnt_q + 3'd1;
`ifdef SAFEBOX_AUTO_RELOCK_EN
        idle_d    = '0;
`endif

        case (st_q)
            S_LOCKED: begin
                if (bus.key_clear) begin
                    ebuf_d = '0;
                    dcnt_d = '0;
                end else if (bus.key_enter) begin
                    if (full) begin
                        // Compare now so the pulse can lead the state change by a cycle.
                        st_d    = S_CHECK;
                        match_d = (ebuf_q == code_q);
                        ok_d    = (ebuf_q == code_q);
                        err_d   = (ebuf_q != code_q);
                    end else begin
                        err_d  = 1'b1;
                        ebuf_d = '0;
                        dcnt_d = '0;
                    end
                end else if (bus.key_valid && !full) begin
                    ebuf_d = shifted;
                    dcnt_d = dcnt_q + 4'd1;
                end
            end

            S_CHECK: begin
                ebuf_d = '0;
                dcnt_d = '0;
                if (match_q) begin
                    st_d   = S_OPEN;
                    fcnt_d = '0;
                end else begin
                    fcnt_d = fail_next;
                    if (fail_next == 3'(MAX_FAIL)) begin
                        st_d  = S_LOCKOUT;
                        tmr_d = TW'(LOCKOUT_CYCLES - 1);
                    end else begin
                        st_d = S_LOCKED;
                    end
                end
            end

            S_OPEN: begin
                if (bus.lock_cmd) begin
                    st_d = S_LOCKED;
                end else if (bus.set_cmd) begin
                    st_d = S_OPEN_SET;
                end
                ebuf_d = '0;
                dcnt_d = '0;
            end

            S_OPEN_SET: begin
                if (bus.lock_cmd) begin
                    st_d   = S_LOCKED;
                    ebuf_d = '0;
                    dcnt_d = '0;
                end else if (bus.key_clear) begin
                    ebuf_d = '0;
                    dcnt_d = '0;
                end else if (bus.key_enter) begin
                    if (full) begin
                        code_d = ebuf_q;
                        ok_d   = 1'b1;
                        st_d   = S_OPEN;
                    end else begin
                        err_d = 1'b1;
                    end
                    ebuf_d = '0;
                    dcnt_d = '0;
                end else if (bus.key_valid && !full) begin
                    ebuf_d = shifted;
                    dcnt_d = dcnt_q + 4'd1;
                end
            end

            S_LOCKOUT: begin
                if (tmr_q == '0) begin
                    st_d   = S_LOCKED;
                    fcnt_d = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end

            default: begin
                st_d = S_LOCKED;
            end
        endcase

`ifdef SAFEBOX_AUTO_RELOCK_EN
        if ((st_q == S_OPEN || st_q == S_OPEN_SET) && !bus.lock_cmd) begin
            if (bus.key_valid || bus.key_enter || bus.key_clear || bus.set_cmd) begin
                idle_d = '0;
            end else if (idle_q == TW'(AUTO_RELOCK_CYCLES - 1)) begin
                st_d   = S_LOCKED;
                ebuf_d = '0;
                dcnt_d = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= S_LOCKED;
            code_q    <= DEFAULT_CODE;
            ebuf_q    <= '0;
            dcnt_q    <= '0;
            fcnt_q    <= '0;
            tmr_q     <= '0;
            match_q   <= 1'b0;
            err_q     <= 1'b0;
            ok_q      <= 1'b0;
            state_q   <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            code_q    <= code_d;
            ebuf_q    <= ebuf_d;
            dcnt_q    <= dcnt_d;
            fcnt_q    <= fcnt_d;
            tmr_q     <= tmr_d;
            match_q   <= match_d;
            err_q     <= err_d;
            ok_q      <= ok_d;
            state_q   <= (st_d == S_OPEN) || (st_d == S_OPEN_SET);
            lockout_q <= (st_d == S_LOCKOUT);
        end
    end

`ifdef SAFEBOX_AUTO_RELOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    assign bus.state     = state_q;
    assign bus.lockout   = lockout_q;
    assign bus.fail_cnt  = fcnt_q;
    assign bus.digit_cnt = dcnt_q;
    assign bus.err_pulse = err_q;
    assign bus.ok_pulse  = ok_q;
endmodule

// File: tb/tb_safebox_lock_ctrl.sv
// Bench for safebox_lock_ctrl: directed scenarios plus random keypad episodes against a behavioural model.
module tb_safebox_lock_ctrl;
    localparam int          DIGITS             = 4;
    localparam logic [15:0] DEFAULT_CODE       = 16'h1234;
    localparam int          MAX_FAIL           = 3;
    localparam int          LOCKOUT_CYCLES     = 20;
    localparam int          AUTO_RELOCK_CYCLES = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    safebox_lock_ctrl_if bus();

    safebox_lock_ctrl #(
        .DIGITS(DIGITS),
        .DEFAULT_CODE(DEFAULT_CODE),
        .MAX_FAIL(MAX_FAIL),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
        .AUTO_RELOCK_CYCLES(AUTO_RELOCK_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: digits as a queue, lockout as cycles remaining.
    int m_code[DIGITS];
    int m_q[$];
    bit m_open, m_setting, m_pend, m_pend_ok, m_err, m_ok;
    int m_lock_left, m_fails, m_idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        logic [15:0] dc;
        dc = DEFAULT_CODE;
        for (int i = 0; i < DIGITS; i++) m_code[i] = int'((dc >> (4 * (DIGITS - 1 - i))) & 16'hF);
        m_q.delete();
        m_open = 0; m_setting = 0; m_pend = 0; m_pend_ok = 0; m_err = 0; m_ok = 0;
        m_lock_left = 0; m_fails = 0; m_idle = 0;
    endfunction

    function automatic bit entry_matches();
        if (m_q.size() != DIGITS) return 0;
        for (int i = 0; i < DIGITS; i++) if (m_q[i] != m_code[i]) return 0;
        return 1;
    endfunction

    function automatic void model_step(bit v, int kc, bit e, bit c, bit l, bit s);
        m_err = 0;
        m_ok  = 0;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (m_pend) begin
            m_pend = 0;
            m_q.delete();
            if (m_pend_ok) begin
                m_open = 1; m_fails = 0; m_idle = 0;
            end else begin
                m_fails = (m_fails + 1 > MAX_FAIL) ? MAX_FAIL : m_fails + 1;
                if (m_fails == MAX_FAIL) m_lock_left = LOCKOUT_CYCLES;
            end
        end else if (m_open) begin
            if (l) begin
                m_open = 0; m_setting = 0; m_q.delete();
            end else begin
                if (m_setting) begin
                    if (c) m_q.delete();
                    else if (e) begin
                        if (m_q.size() == DIGITS) begin
                            for (int i = 0; i < DIGITS; i++) m_code[i] = m_q[i];
                            m_ok = 1; m_setting = 0;
                        end else m_err = 1;
                        m_q.delete();
                    end else if (v && m_q.size() < DIGITS) m_q.push_back(kc);
                end else if (s) m_setting = 1;
`ifdef SAFEBOX_AUTO_RELOCK_EN
                if (v || e || c || s) m_idle = 0;
                else if (m_idle == AUTO_RELOCK_CYCLES - 1) begin
                    m_open = 0; m_setting = 0; m_q.delete(); m_idle = 0;
                end else m_idle++;
`endif
            end
        end else begin
            if (c) m_q.delete();
            else if (e) begin
                if (m_q.size() == DIGITS) begin
                    m_pend = 1; m_pend_ok = entry_matches();
                    m_ok = m_pend_ok; m_err = !m_pend_ok;
                end else begin
                    m_err = 1; m_q.delete();
                end
            end else if (v && m_q.size() < DIGITS) m_q.push_back(kc);
        end
        if (!m_open) m_idle = 0;
    endfunction

    function automatic logic [10:0] exp_outs();
        return {m_open, (m_lock_left > 0), 3'(m_fails), 4'(m_q.size()), m_err, m_ok};
    endfunction

    function automatic logic [10:0] dut_outs();
        return {bus.state, bus.lockout, bus.fail_cnt, bus.digit_cnt, bus.err_pulse, bus.ok_pulse};
    endfunction

    task automatic tick(input bit v, input int kc, input bit e, input bit c, input bit l, input bit s);
        bus.key_valid = v; bus.key_code = 4'(kc); bus.key_enter = e;
        bus.key_clear = c; bus.lock_cmd = l; bus.set_cmd = s;
        @(posedge clk);
        model_step(v, kc, e, c, l, s);
        #1;
        check("outs", 32'(dut_outs()), 32'(exp_outs()));
        bus.key_valid = 0; bus.key_code = 0; bus.key_enter = 0;
        bus.key_clear = 0; bus.lock_cmd = 0; bus.set_cmd = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic key(input int d);
        tick(1, d, 0, 0, 0, 0);
    endtask

    task automatic enter();
        tick(0, 0, 1, 0, 0, 0);
    endtask

    task automatic lock();
        tick(0, 0, 0, 0, 1, 0);
    endtask

    task automatic digits(input logic [15:0] cv);
        for (int i = 0; i < 4; i++) key(int'(cv[15 - 4 * i -: 4]));
    endtask

    task automatic model_code_entry();
        int cpy[DIGITS];
        for (int i = 0; i < DIGITS; i++) cpy[i] = m_code[i];
        for (int i = 0; i < DIGITS; i++) key(cpy[i]);
    endtask

    task automatic async_rst(input string tag);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check(tag, 32'(dut_outs()), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.key_valid = 0; bus.key_code = 0; bus.key_enter = 0;
        bus.key_clear = 0; bus.lock_cmd = 0; bus.set_cmd = 0;
        model_reset();
        #12 check("reset", 32'(dut_outs()), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Short entry is an error without counting a failure.
        key(1); key(2); enter();
        check("short_err", 32'(bus.err_pulse), 32'd1);
        check("short_fail", 32'(bus.fail_cnt), 32'd0);
        check("short_dcnt", 32'(bus.digit_cnt), 32'd0);

        // Fifth digit ignored; opening latency.
        key(1); key(2); key(3); key(4); key(5);
        check("full_dcnt", 32'(bus.digit_cnt), 32'd4);
        enter();
        check("ok_n1", 32'(bus.ok_pulse), 32'd1);
        check("state_n1", 32'(bus.state), 32'd0);
        idle(1);
        check("state_n2", 32'(bus.state), 32'd1);
        lock();
        check("relock", 32'(bus.state), 32'd0);

        // Clear beats enter.
        digits(16'h1234);
        tick(0, 0, 1, 1, 0, 0);
        check("clr_enter_dcnt", 32'(bus.digit_cnt), 32'd0);
        idle(1);
        check("clr_enter_state", 32'(bus.state), 32'd0);

        // Three failures then lockout with ignored keys.
        for (int k = 1; k <= 3; k++) begin
            digits(16'h0000); enter();
            check("bad_err", 32'(bus.err_pulse), 32'd1);
            idle(1);
            check("bad_fail", 32'(bus.fail_cnt), 32'(k));
        end
        check("lockout_on", 32'(bus.lockout), 32'd1);
        repeat (LOCKOUT_CYCLES - 1)
            tick($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        check("lockout_hold", 32'(bus.lockout), 32'd1);
        idle(1);
        check("lockout_off", 32'(bus.lockout), 32'd0);
        check("lockout_fail0", 32'(bus.fail_cnt), 32'd0);

        // Code change.
        digits(16'h1234); enter(); idle(1);
        tick(0, 0, 0, 0, 0, 1);
        digits(16'h9876); enter();
        check("set_ok", 32'(bus.ok_pulse), 32'd1);
        lock();
        digits(16'h1234); enter(); idle(1);
        check("old_code_state", 32'(bus.state), 32'd0);
        check("old_code_fail", 32'(bus.fail_cnt), 32'd1);
        digits(16'h9876); enter(); idle(1);
        check("new_code_state", 32'(bus.state), 32'd1);
        lock();

        // Async reset mid-lockout and mid-code-change.
        for (int k = 0; k < 3; k++) begin digits(16'h0000); enter(); idle(1); end
        idle(5);
        async_rst("rst_lockout");
        digits(16'h1234); enter(); idle(1);
        check("code_restored", 32'(bus.state), 32'd1);
        tick(0, 0, 0, 0, 0, 1);
        key(9); key(8);
        async_rst("rst_set");
        digits(16'h1234); enter(); idle(1);
        check("code_restored2", 32'(bus.state), 32'd1);
        lock();

`ifdef SAFEBOX_AUTO_RELOCK_EN
        model_code_entry(); enter(); idle(1);
        idle(AUTO_RELOCK_CYCLES - 1);
        check("auto_hold", 32'(bus.state), 32'd1);
        idle(1);
        check("auto_relock", 32'(bus.state), 32'd0);
        model_code_entry(); enter(); idle(1);
        idle(24); key(5);
        idle(AUTO_RELOCK_CYCLES - 1);
        check("auto_restart_hold", 32'(bus.state), 32'd1);
        idle(1);
        check("auto_restart_relock", 32'(bus.state), 32'd0);
`endif

        // Random keypad episodes.
        repeat (200) begin
            case ($urandom_range(0, 5))
                0: begin model_code_entry(); enter(); idle(1); end
                1: begin
                    repeat ($urandom_range(0, 5)) begin
                        if ($urandom_range(0, 7) == 0) tick(0, 0, 0, 1, 0, 0);
                        else key($urandom_range(0, 15));
                    end
                    enter(); idle(1);
                end
                2: begin
                    tick(0, 0, 0, 0, 0, 1);
                    repeat (DIGITS) key($urandom_range(0, 15));
                    enter();
                end
                3: lock();
                4: repeat ($urandom_range(1, 3))
                    tick($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
                         $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
                default: idle($urandom_range(1, 6));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
